map_ram: RTL and testbench
==========================

Name: map_ram

Overview:
- Writable, parametrised successor to the fixed combinational map lookup.
- Holds a MAP_W x MAP_H grid of VAL_BITS-wide wall codes.
- Self-initialises to the standard border+diagonal layout after reset or on a clear command.
- Serves the ray tracer through a registered read port; accepts single-cell edits from the host/SPI side through a req/ack write port.

Parameters:
MAP_WBITS, 4, column index width; MAP_W = 1<<MAP_WBITS
MAP_HBITS, 4, row index width; MAP_H = 1<<MAP_HBITS
VAL_BITS, 2, bits per cell; cell value 0 = empty
INIT_MODE, 1, 0 = fill all zero; 1 = border+diagonal pattern
LOCK_BORDER, 1, 1 = writes to border cells are acked but discarded

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_col  in  MAP_WBITS  tracer read column
i_row  in  MAP_HBITS  tracer read row
o_val  out  VAL_BITS  cell value for the address presented on the previous cycle
o_ready  out  1  high when init is complete and the map is valid
i_clear  in  1  one-cycle pulse; re-runs init
i_wr_req  in  1  write request; held high until ack
i_wr_col  in  MAP_WBITS  write column
i_wr_row  in  MAP_HBITS  write row
i_wr_val  in  VAL_BITS  write data
o_wr_ack  out  1  one-cycle pulse when the write is consumed

Behaviour:
- Reset values: o_val=0, o_ready=0, o_wr_ack=0. FSM enters INIT with the cursor at (row 0, col 0).
- FSM states: INIT, IDLE, ACK.
- INIT:
  - Writes one cell per cycle, row-major: col increments; on col wrap to 0, row increments.
  - Value = pattern(row, col) when INIT_MODE=1, else 0.
  - After writing cell (MAP_H-1, MAP_W-1), goes to IDLE next cycle. Total MAP_W*MAP_H cycles; 256 at defaults.
  - o_ready goes high on the first IDLE cycle.
- Pattern (INIT_MODE=1): bit0 = 1 when any of these hold, all other bits 0:
  - col==0 or col==MAP_W-1 or row==0 or row==MAP_H-1, or
  - row+col==7 with row<8 and col<8; this term is only present when MAP_WBITS>=3 and MAP_HBITS>=3.
- Read port:
  - o_val is registered from (i_col, i_row); 1-cycle latency, one read every cycle.
  - While o_ready=0, o_val is forced to 0.
- Write port:
  - In IDLE with i_wr_req=1, the cell is written and the FSM enters ACK.
  - ACK drives o_wr_ack=1 for exactly one cycle, then returns to IDLE. This gives at most one write per 2 cycles.
  - The requester must drop i_wr_req in the ack cycle, or a new write starts.
  - During INIT, requests are not acked; the requester holds them. The first request is serviced in the first IDLE cycle.
  - LOCK_BORDER=1 and target is a border cell: no storage change, but o_wr_ack still pulses.
- Read/write collision (same cell, same cycle): o_val returns the old value (read-before-write). The new value is visible from the following read.
- i_clear:
  - In IDLE or ACK: enters INIT next cycle, cursor reset, o_ready drops. A pending ACK pulse still completes in that cycle.
  - During INIT: restarts INIT from (0,0).
  - i_clear and i_wr_req in the same IDLE cycle: clear wins, the write is not performed and not acked.
- reset mid-INIT or mid-ACK: return to reset state immediately; no ack is emitted.
- Storage is a plain register array, MAP_W*MAP_H*VAL_BITS bits, with no reset of its own. Contents are defined only by INIT.

Decomposition:
- Package map_pkg holds:
  - state encoding (INIT/IDLE/ACK);
  - VAL_EMPTY=0, VAL_WALL=1;
  - function is_border(row, col) for given widths.
- Natural sub-module: map_init_pattern. Combinational (row, col) -> pattern value; shared with is_border for the LOCK_BORDER check.
- Top holds the FSM, cursor counters, storage and read register.

Test Plan:
- Reset, then wait: o_ready rises exactly 257 cycles after reset deasserts at defaults. Then read (0,5)->1, (15,15)->1, (3,4)->1, (5,5)->0, (8,8)->0.
- Write (5,5)=2 in IDLE: o_wr_ack pulses one cycle later. The next read of (5,5) returns 2; reading (5,5) in the same cycle as the write returns 0.
- LOCK_BORDER=1, write (0,7)=3: ack pulses, read (0,7) still 1. Repeat with LOCK_BORDER=0: read returns 3.
- Hold i_wr_req (9,9)=1 from reset: no ack during INIT. Ack arrives in the cycle after o_ready rises; read (9,9)->1.
- Write (5,5)=2, then pulse i_clear: o_ready drops next cycle, o_val reads 0 during INIT. After 256 cycles, (5,5)->0 again. Pulse i_clear at init cycle 100: completion is 256 cycles after that pulse.
- MAP_WBITS=5, MAP_HBITS=3, INIT_MODE=0: o_ready rises after 256 init cycles and every cell reads 0. Write (31,7)=1 with LOCK_BORDER=0: reads back 1.

Source files
------------

// File: rtl/map_pkg.sv
// Shared types and helpers for the writable wall-map RAM.
package map_pkg;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_ACK  = 2'd2
   } map_state_t;

   localparam int unsigned VAL_EMPTY = 0;
   localparam int unsigned VAL_WALL  = 1;

   // True on the outer ring of a (1<<hbits) x (1<<wbits) grid.
   function automatic logic is_border(input int unsigned row, input int unsigned col,
                                      input int unsigned wbits, input int unsigned hbits);
      return (col == 0) || (col == (32'd1 << wbits) - 32'd1) ||
             (row == 0) || (row == (32'd1 << hbits) - 32'd1);
   endfunction

endpackage

// File: rtl/map_ram_if.sv
// Tracer read port, clear control and host write handshake of map_ram.
interface map_ram_if #(
   parameter int unsigned MAP_WBITS = 4,
   parameter int unsigned MAP_HBITS = 4,
   parameter int unsigned VAL_BITS  = 2
);
   logic [MAP_WBITS-1:0] i_col;
   logic [MAP_HBITS-1:0] i_row;
   logic [VAL_BITS-1:0]  o_val;
   logic                 o_ready;
   logic                 i_clear;
   logic                 i_wr_req;
   logic [MAP_WBITS-1:0] i_wr_col;
   logic [MAP_HBITS-1:0] i_wr_row;
   logic [VAL_BITS-1:0]  i_wr_val;
   logic                 o_wr_ack;

   modport master (
      output i_col, i_row, i_clear, i_wr_req, i_wr_col, i_wr_row, i_wr_val,
      input  o_val, o_ready, o_wr_ack
   );

   modport slave (
      input  i_col, i_row, i_clear, i_wr_req, i_wr_col, i_wr_row, i_wr_val,
      output o_val, o_ready, o_wr_ack
   );
endinterface

// File: rtl/map_init_pattern.sv
// Combinational default-layout generator: border ring plus the row+col==7 diagonal.
module map_init_pattern
   import map_pkg::*;
#(
   parameter int unsigned MAP_WBITS = 4,
   parameter int unsigned MAP_HBITS = 4,
   parameter int unsigned VAL_BITS  = 2,
   parameter int unsigned INIT_MODE = 1
) (
   input  logic [MAP_HBITS-1:0] row,
   input  logic [MAP_WBITS-1:0] col,
   output logic [VAL_BITS-1:0]  val
);
   // Diagonal only fits when both dimensions reach at least 8 cells.
   localparam bit HAS_DIAG = (MAP_WBITS >= 3) && (MAP_HBITS >= 3);

   logic border;
   logic diag;

   always_comb begin
      border = is_border(32'(row), 32'(col), MAP_WBITS, MAP_HBITS);
      diag   = HAS_DIAG && (32'(row) < 32'd8) && (32'(col) < 32'd8) &&
               ((32'(row) + 32'(col)) == 32'd7);
      val    = ((INIT_MODE != 0) && (border || diag)) ? VAL_BITS'(VAL_WALL)
                                                     : VAL_BITS'(VAL_EMPTY);
   end

endmodule

// File: rtl/map_ram.sv
// Writable wall map: self-initialising cell store with registered tracer read port
// and a req/ack single-cell write port.
module map_ram
   import map_pkg::*;
#(
   parameter int unsigned MAP_WBITS   = 4,
   parameter int unsigned MAP_HBITS   = 4,
   parameter int unsigned VAL_BITS    = 2,
   parameter int unsigned INIT_MODE   = 1,
   parameter int unsigned LOCK_BORDER = 1
) (
   input  logic     clk,
   input  logic     reset,
   map_ram_if.slave bus
);
   localparam int unsigned MAP_W = 1 << MAP_WBITS;
   localparam int unsigned MAP_H = 1 << MAP_HBITS;
   localparam int unsigned CELLS = MAP_W * MAP_H;
   localparam int unsigned ABITS = MAP_WBITS + MAP_HBITS;

   map_state_t           state;
   logic [MAP_WBITS-1:0] cur_col;
   logic [MAP_HBITS-1:0] cur_row;
   logic [VAL_BITS-1:0]  mem [CELLS];

   logic [VAL_BITS-1:0]  init_val;
   logic                 last_cell;
   logic                 wr_go;
   logic                 wr_locked;
   logic                 mem_we;
   logic [ABITS-1:0]     mem_addr;
   logic [VAL_BITS-1:0]  mem_data;
   logic [ABITS-1:0]     rd_addr;
   logic                 ready_nxt;

   map_init_pattern #(
      .MAP_WBITS (MAP_WBITS),
      .MAP_HBITS (MAP_HBITS),
      .VAL_BITS  (VAL_BITS),
      .INIT_MODE (INIT_MODE)
   ) u_pattern (
      .row (cur_row),
      .col (cur_col),
      .val (init_val)
   );

   // Storage port arbitration: init sweep owns the array, otherwise the host write.
   always_comb begin
      last_cell = (&cur_col) && (&cur_row);
      wr_go     = (state == ST_IDLE) && bus.i_wr_req && !bus.i_clear;
      wr_locked = (LOCK_BORDER != 0) &&
                  is_border(32'(bus.i_wr_row), 32'(bus.i_wr_col), MAP_WBITS, MAP_HBITS);
      rd_addr   = {bus.i_row, bus.i_col};
      mem_we    = 1'b0;
      mem_addr  = {cur_row, cur_col};
      mem_data  = init_val;
      if (!reset) begin
         if ((state == ST_INIT) && !bus.i_clear) begin
            mem_we = 1'b1;
         end else if (wr_go && !wr_locked) begin
            mem_we   = 1'b1;
            mem_addr = {bus.i_wr_row, bus.i_wr_col};
            mem_data = bus.i_wr_val;
         end
      end
      ready_nxt = 1'b0;
      if (!reset && !bus.i_clear) begin
         case (state)
            ST_INIT:         ready_nxt = last_cell;
            ST_IDLE, ST_ACK: ready_nxt = 1'b1;
            default:         ready_nxt = 1'b0;
         endcase
      end
   end

   // Cell store has no reset; its contents come only from the init sweep and writes.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_data;
   end

   // Control FSM, init cursor and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_INIT;
         cur_col      <= '0;
         cur_row      <= '0;
         bus.o_ready  <= 1'b0;
         bus.o_val    <= '0;
         bus.o_wr_ack <= 1'b0;
      end else begin
         bus.o_ready  <= ready_nxt;
         bus.o_val    <= ready_nxt ? mem[rd_addr] : '0;
         bus.o_wr_ack <= 1'b0;
         if (bus.i_clear) begin
            state   <= ST_INIT;
            cur_col <= '0;
            cur_row <= '0;
         end else begin
            case (state)
               ST_INIT: begin
                  cur_col <= cur_col + MAP_WBITS'(1);
                  if (&cur_col) cur_row <= cur_row + MAP_HBITS'(1);
                  if (last_cell) state <= ST_IDLE;
               end
               ST_IDLE: begin
                  if (bus.i_wr_req) begin
                     state        <= ST_ACK;
                     bus.o_wr_ack <= 1'b1;
                  end
               end
               ST_ACK:  state <= ST_IDLE;
               default: state <= ST_INIT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_map_ram.sv
// Directed bench for map_ram: default map, unlocked-border map and a 32x8 zero-filled map.
module tb_map_ram;

   logic clk;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   cyc;
   int   k;
   int   nz;
   bit   seen_ack;

   map_ram_if #(.MAP_WBITS(4), .MAP_HBITS(4), .VAL_BITS(2)) ia ();
   map_ram_if #(.MAP_WBITS(4), .MAP_HBITS(4), .VAL_BITS(2)) ib ();
   map_ram_if #(.MAP_WBITS(5), .MAP_HBITS(3), .VAL_BITS(2)) ic ();

   map_ram #(.MAP_WBITS(4), .MAP_HBITS(4), .VAL_BITS(2), .INIT_MODE(1), .LOCK_BORDER(1))
      u_a (.clk(clk), .reset(reset), .bus(ia.slave));
   map_ram #(.MAP_WBITS(4), .MAP_HBITS(4), .VAL_BITS(2), .INIT_MODE(1), .LOCK_BORDER(0))
      u_b (.clk(clk), .reset(reset), .bus(ib.slave));
   map_ram #(.MAP_WBITS(5), .MAP_HBITS(3), .VAL_BITS(2), .INIT_MODE(0), .LOCK_BORDER(0))
      u_c (.clk(clk), .reset(reset), .bus(ic.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic rd_a(input int row, input int col, input int exp, input string tag);
      ia.i_row = 4'(row);
      ia.i_col = 4'(col);
      step();
      chk(tag, 32'(ia.o_val), 32'(exp));
   endtask

   initial begin
      reset = 1'b1;
      ia.i_col = '0; ia.i_row = '0; ia.i_clear = 1'b0;
      ib.i_col = '0; ib.i_row = '0; ib.i_clear = 1'b0;
      ic.i_col = '0; ic.i_row = '0; ic.i_clear = 1'b0;
      ib.i_wr_req = 1'b0; ib.i_wr_col = '0; ib.i_wr_row = '0; ib.i_wr_val = '0;
      ic.i_wr_req = 1'b0; ic.i_wr_col = '0; ic.i_wr_row = '0; ic.i_wr_val = '0;
      // A holds a write of (9,9)=1 across reset and the whole init sweep
      ia.i_wr_req = 1'b1; ia.i_wr_row = 4'd9; ia.i_wr_col = 4'd9; ia.i_wr_val = 2'd1;

      step();
      step();
      chk("rst_ready", 32'(ia.o_ready), 32'd0);
      chk("rst_val", 32'(ia.o_val), 32'd0);
      chk("rst_ack", 32'(ia.o_wr_ack), 32'd0);

      // cycle 1 is the one in which reset drops
      reset = 1'b0;
      cyc = 1;
      seen_ack = 1'b0;
      while (!ia.o_ready && cyc < 400) begin
         step();
         cyc++;
         if (ia.o_wr_ack) seen_ack = 1'b1;
      end
      chk("ready_cycle", 32'(cyc), 32'd257);
      chk("no_ack_in_init", 32'(seen_ack), 32'd0);
      chk("c_ready", 32'(ic.o_ready), 32'd1);

      step();
      chk("held_req_ack", 32'(ia.o_wr_ack), 32'd1);
      ia.i_wr_req = 1'b0;
      step();
      chk("ack_one_cycle", 32'(ia.o_wr_ack), 32'd0);

      rd_a(0, 5, 1, "rd_0_5");
      rd_a(15, 15, 1, "rd_15_15");
      rd_a(3, 4, 1, "rd_3_4_diag");
      rd_a(5, 5, 0, "rd_5_5");
      rd_a(8, 8, 0, "rd_8_8");
      rd_a(9, 9, 1, "rd_9_9_held_write");

      // write (5,5)=2 while reading the same cell: old value comes back
      ia.i_wr_req = 1'b1; ia.i_wr_row = 4'd5; ia.i_wr_col = 4'd5; ia.i_wr_val = 2'd2;
      ia.i_row = 4'd5; ia.i_col = 4'd5;
      step();
      chk("wr55_ack", 32'(ia.o_wr_ack), 32'd1);
      chk("wr55_collide_old", 32'(ia.o_val), 32'd0);
      ia.i_wr_req = 1'b0;
      step();
      chk("wr55_readback", 32'(ia.o_val), 32'd2);

      // border write (0,7)=3: locked on A, accepted on B
      ia.i_wr_req = 1'b1; ia.i_wr_row = 4'd0; ia.i_wr_col = 4'd7; ia.i_wr_val = 2'd3;
      ib.i_wr_req = 1'b1; ib.i_wr_row = 4'd0; ib.i_wr_col = 4'd7; ib.i_wr_val = 2'd3;
      step();
      chk("lock_ack", 32'(ia.o_wr_ack), 32'd1);
      chk("unlock_ack", 32'(ib.o_wr_ack), 32'd1);
      ia.i_wr_req = 1'b0;
      ib.i_wr_req = 1'b0;
      ia.i_row = 4'd0; ia.i_col = 4'd7;
      ib.i_row = 4'd0; ib.i_col = 4'd7;
      step();
      step();
      chk("lock_kept", 32'(ia.o_val), 32'd1);
      chk("unlock_written", 32'(ib.o_val), 32'd3);

      // zero-filled 32x8 map
      nz = 0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 32; c++) begin
            ic.i_row = 3'(r);
            ic.i_col = 5'(c);
            step();
            if (ic.o_val != 2'd0) nz++;
         end
      end
      chk("c_all_zero", 32'(nz), 32'd0);
      ic.i_wr_req = 1'b1; ic.i_wr_row = 3'd7; ic.i_wr_col = 5'd31; ic.i_wr_val = 2'd1;
      step();
      chk("c_wr_ack", 32'(ic.o_wr_ack), 32'd1);
      ic.i_wr_req = 1'b0;
      ic.i_row = 3'd7; ic.i_col = 5'd31;
      step();
      chk("c_readback", 32'(ic.o_val), 32'd1);

      // clear from IDLE on A
      ia.i_clear = 1'b1;
      step();
      ia.i_clear = 1'b0;
      k = 0;
      chk("clr_ready_drop", 32'(ia.o_ready), 32'd0);
      ia.i_row = 4'd0; ia.i_col = 4'd0;
      step();
      k++;
      chk("clr_val_forced", 32'(ia.o_val), 32'd0);
      while (!ia.o_ready && k < 400) begin
         step();
         k++;
      end
      chk("clr_done_cycles", 32'(k), 32'd256);
      rd_a(5, 5, 0, "clr_5_5_restored");
      rd_a(0, 0, 1, "clr_0_0_wall");

      // clear again, then restart init 100 cycles in
      ia.i_clear = 1'b1;
      step();
      ia.i_clear = 1'b0;
      for (int i = 0; i < 100; i++) step();
      chk("mid_init_not_ready", 32'(ia.o_ready), 32'd0);
      ia.i_clear = 1'b1;
      step();
      ia.i_clear = 1'b0;
      k = 0;
      while (!ia.o_ready && k < 400) begin
         step();
         k++;
      end
      chk("restart_done_cycles", 32'(k), 32'd256);

      // clear and write together in IDLE: clear wins, no ack
      ia.i_wr_req = 1'b1; ia.i_wr_row = 4'd6; ia.i_wr_col = 4'd6; ia.i_wr_val = 2'd3;
      ia.i_clear = 1'b1;
      step();
      ia.i_clear = 1'b0;
      ia.i_wr_req = 1'b0;
      chk("clr_wr_no_ack", 32'(ia.o_wr_ack), 32'd0);
      chk("clr_wr_ready_drop", 32'(ia.o_ready), 32'd0);
      step();
      chk("clr_wr_no_late_ack", 32'(ia.o_wr_ack), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
